// File: rtl/clk_pkg.sv
// Shared constants and helpers for the tick generator: system clock rate,
// divisor calculation and the default 1 Hz / 2 Hz / 4 kHz divisor set.
package clk_pkg;

   localparam int unsigned CLK_HZ      = 50_000_000;
   localparam int          DEF_NUM_CH  = 3;
   localparam int          DEF_CNT_W   = 26;

   // Nearest even number of clk cycles per period for the requested rate.
   function automatic int unsigned div_from_hz(input int unsigned hz);
      return ((CLK_HZ + hz) / (2 * hz)) * 2;
   endfunction

   localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEFAULT_DIV_VEC = {
      DEF_CNT_W'(div_from_hz(4000)),
      DEF_CNT_W'(div_from_hz(2)),
      DEF_CNT_W'(div_from_hz(1))
   };

endpackage

// File: rtl/clk_tick_gen_if.sv
// Control and output bundle of the tick generator; the master side drives
// the enables, the slave side (the generator) returns ticks and square waves.
interface clk_tick_gen_if #(
   parameter int NUM_CH = 3
);

   logic              en;
   logic              sync_clr;
   logic              fast;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;

   modport master (output en, output sync_clr, output fast, input tick, input sq);
   modport slave  (input en, input sync_clr, input fast, output tick, output sq);

endinterface

// File: rtl/clk_tick_chan.sv
// One divider channel: a period counter plus registered tick pulse and
// 50 % square wave, with a selectable fast-mode divisor.
module clk_tick_chan
   import clk_pkg::*;
#(
   parameter int               CNT_W      = 26,
   parameter logic [CNT_W-1:0] DIV        = CNT_W'(CLK_HZ),
   parameter int               FAST_SHIFT = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sync_clr,
   input  logic fast,
   output logic tick,
   output logic sq
);

   localparam logic [CNT_W-1:0] DIV_SHR = DIV >> FAST_SHIFT;
   localparam logic [CNT_W-1:0] E_FAST  = (DIV_SHR < CNT_W'(2)) ? CNT_W'(2)
                                        : (DIV_SHR & ~CNT_W'(1));

   if (DIV < CNT_W'(4) || DIV[0]) begin : g_bad_div
      $error("clk_tick_chan: divisor %0d must be even and at least 4", DIV);
   end

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] e_eff;
   logic [CNT_W-1:0] last;
   logic [CNT_W-1:0] half;

   assign e_eff = fast ? E_FAST : DIV;
   assign last  = e_eff - CNT_W'(1);
   assign half  = (e_eff >> 1) - CNT_W'(1);

   // Terminal uses >= so a shrinking divisor wraps at once instead of
   // running the counter all the way round; clearing sq there keeps the
   // square wave in phase after any divisor change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
         sq   <= 1'b0;
      end else if (sync_clr) begin
         cnt  <= '0;
         tick <= 1'b0;
         sq   <= 1'b0;
      end else if (!en) begin
         tick <= 1'b0;
      end else if (cnt >= last) begin
         cnt  <= '0;
         tick <= 1'b1;
         sq   <= 1'b0;
      end else begin
         cnt  <= cnt + CNT_W'(1);
         tick <= 1'b0;
         if (cnt == half) begin
            sq <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel clock divider: fans the shared controls out to one
// clk_tick_chan per rate and collects their tick and square-wave outputs.
module clk_tick_gen
   import clk_pkg::*;
#(
   parameter int                        NUM_CH     = DEF_NUM_CH,
   parameter int                        CNT_W      = DEF_CNT_W,
   parameter logic [NUM_CH*CNT_W-1:0]   DIV_VEC    = DEFAULT_DIV_VEC,
   parameter int                        FAST_SHIFT = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   clk_tick_gen_if.slave  bus
);

   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("clk_tick_gen: NUM_CH=%0d outside 1..8", NUM_CH);
   end

   logic [NUM_CH-1:0] tick_w;
   logic [NUM_CH-1:0] sq_w;

   // Each divisor is a CNT_W-bit slice, so it always fits the counter.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      clk_tick_chan #(
         .CNT_W      (CNT_W),
         .DIV        (DIV_VEC[i*CNT_W +: CNT_W]),
         .FAST_SHIFT (FAST_SHIFT)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (bus.en),
         .sync_clr (bus.sync_clr),
         .fast     (bus.fast),
         .tick     (tick_w[i]),
         .sq       (sq_w[i])
      );
   end

   assign bus.tick = tick_w;
   assign bus.sq   = sq_w;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench for clk_tick_gen: a period/phase reference model queues the
// expected outputs per cycle and a monitor compares them after each clk edge.
module tb_clk_tick_gen;

   localparam int NCH = 3;
   localparam int CW  = 8;
   localparam int FS  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   clk_tick_gen_if #(.NUM_CH(NCH)) bus ();

   clk_tick_gen #(
      .NUM_CH     (NCH),
      .CNT_W      (CW),
      .DIV_VEC    ({8'd8, 8'd20, 8'd40}),
      .FAST_SHIFT (FS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int align_bad = 0;
   bit align_on  = 1'b0;
   int tick_cnt[NCH];
   int first_tick[NCH];
   int divs[NCH] = '{40, 20, 8};

   logic [5:0] exp_q[$];
   logic [5:0] mon_got;
   logic [5:0] mon_exp;

   int phase[NCH];
   bit mt[NCH];
   bit ms[NCH];

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic int effDiv(input int d, input bit f);
      int e;
      if (!f) return d;
      e = d >> FS;
      if (e < 2) e = 2;
      return e - (e % 2);
   endfunction

   // Reference: each enabled cycle advances the phase within a period of E
   // cycles; the period ends once the phase has reached E-1.
   task automatic modelStep(input bit r, input bit e, input bit c, input bit f);
      for (int i = 0; i < NCH; i++) begin
         int ed;
         ed = effDiv(divs[i], f);
         if (!r || c) begin
            phase[i] = 0; mt[i] = 1'b0; ms[i] = 1'b0;
         end else if (!e) begin
            mt[i] = 1'b0;
         end else if (phase[i] >= ed - 1) begin
            phase[i] = 0; mt[i] = 1'b1; ms[i] = 1'b0;
         end else begin
            mt[i] = 1'b0;
            phase[i] = phase[i] + 1;
            if (phase[i] == ed / 2) ms[i] = 1'b1;
         end
      end
   endtask

   task automatic pushExpected();
      exp_q.push_back({mt[2], mt[1], mt[0], ms[2], ms[1], ms[0]});
   endtask

   task automatic applyStimulus(input bit r, input bit e, input bit c, input bit f);
      @(negedge clk);
      rst_n        = r;
      bus.en       = e;
      bus.sync_clr = c;
      bus.fast     = f;
      modelStep(r, e, c, f);
      pushExpected();
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic clearFirst();
      for (int i = 0; i < NCH; i++) first_tick[i] = -1;
   endtask

   task automatic doReset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_tick", 32'(bus.tick), 32'd0);
      checkOutput("async_rst_sq",   32'(bus.sq),   32'd0);
      modelStep(1'b0, 1'b0, 1'b0, 1'b0);
      pushExpected();
   endtask

   task automatic checkFirst(input string name, input int base);
      checkOutput({name, "_ch2"}, 32'(first_tick[2]), 32'(base + 8));
      checkOutput({name, "_ch1"}, 32'(first_tick[1]), 32'(base + 20));
      checkOutput({name, "_ch0"}, 32'(first_tick[0]), 32'(base + 40));
   endtask

   function automatic int sumTicks();
      return tick_cnt[0] + tick_cnt[1] + tick_cnt[2];
   endfunction

   // Monitor: one sample per clk edge, popped against the queued expectation.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
         mon_got = {bus.tick, bus.sq};
         mon_exp = exp_q.pop_front();
         checkOutput("sb", 32'(mon_got), 32'(mon_exp));
      end
      for (int i = 0; i < NCH; i++) begin
         if (bus.tick[i]) begin
            tick_cnt[i]++;
            if (first_tick[i] < 0) first_tick[i] = cyc;
         end
      end
      if (align_on && bus.tick[0] && !bus.tick[1]) align_bad++;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base, snap, snap0;
      bit f;
      bus.en = 1'b0; bus.sync_clr = 1'b0; bus.fast = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         phase[i] = 0; mt[i] = 1'b0; ms[i] = 1'b0; tick_cnt[i] = 0;
      end
      clearFirst();

      // Reset release, first ticks, 400-cycle counts and alignment
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      settle();
      base = cyc;
      clearFirst();
      for (int i = 0; i < NCH; i++) tick_cnt[i] = 0;
      align_on = 1'b1;
      repeat (400) applyStimulus(1, 1, 0, 0);
      settle();
      align_on = 1'b0;
      checkFirst("first_tick", base);
      checkOutput("count_ch0", 32'(tick_cnt[0]), 32'd10);
      checkOutput("count_ch1", 32'(tick_cnt[1]), 32'd20);
      checkOutput("count_ch2", 32'(tick_cnt[2]), 32'd50);
      checkOutput("align",     32'(align_bad),   32'd0);

      // Pause at ch0 count 15 for 7 cycles
      applyStimulus(1, 0, 1, 0);
      settle();
      base = cyc;
      repeat (15) applyStimulus(1, 1, 0, 0);
      settle();
      checkOutput("pause_sq_before", 32'(bus.sq), 32'b110);
      snap = sumTicks();
      clearFirst();
      repeat (7) applyStimulus(1, 0, 0, 0);
      settle();
      checkOutput("pause_ticks", 32'(sumTicks() - snap), 32'd0);
      checkOutput("pause_sq_after", 32'(bus.sq), 32'b110);
      repeat (40) applyStimulus(1, 1, 0, 0);
      settle();
      checkOutput("pause_ch0_tick", 32'(first_tick[0]), 32'(base + 47));

      // Fast mode switched in at ch0 count 30
      applyStimulus(1, 0, 1, 0);
      repeat (30) applyStimulus(1, 1, 0, 0);
      settle();
      clearFirst();
      snap0 = tick_cnt[0];
      applyStimulus(1, 1, 0, 1);
      settle();
      checkOutput("fast_wrap", 32'(first_tick[0]), 32'(cyc));
      repeat (40) applyStimulus(1, 1, 0, 1);
      settle();
      checkOutput("fast_count", 32'(tick_cnt[0] - snap0), 32'd5);
      snap0 = tick_cnt[0];
      repeat (80) applyStimulus(1, 1, 0, 0);
      settle();
      checkOutput("slow_again_count", 32'(tick_cnt[0] - snap0), 32'd2);

      // sync_clr on the ch1 terminal cycle
      applyStimulus(1, 0, 1, 0);
      repeat (19) applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 1, 0);
      settle();
      base = cyc;
      checkOutput("clr_tick", 32'(bus.tick), 32'd0);
      checkOutput("clr_sq",   32'(bus.sq),   32'd0);
      clearFirst();
      repeat (44) applyStimulus(1, 1, 0, 0);
      settle();
      checkFirst("clr_first", base);

      // Asynchronous reset mid-period, then restart schedule
      doReset();
      applyStimulus(0, 1, 0, 0);
      settle();
      base = cyc;
      clearFirst();
      repeat (44) applyStimulus(1, 1, 0, 0);
      settle();
      checkFirst("rst_first", base);

      // Randomised mix of enable, restart, fast and reset
      f = 1'b0;
      repeat (600) begin
         if ($urandom_range(0, 39) == 0) f = ~f;
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 9) != 0,
                       $urandom_range(0, 49) == 0,
                       f);
      end
      settle();
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
